// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared FSM encodings, memory command constants and small helpers for the
// single-port memory arbiter.
package sopc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic CE_ON     = 1'b1;
  localparam logic CE_OFF    = 1'b0;
  localparam logic WE_WRITE  = 1'b1;
  localparam logic WE_READ   = 1'b0;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Index width that stays legal (>=1 bit) for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter; slave = arbiter view,
// master = requesters plus memory model view.
interface sopc_mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MASTERS = 2
);
  import sopc_mem_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0]                  m_req;
  logic [NUM_MASTERS-1:0]                  m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       m_addr;
  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   m_sel;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]       m_wdata;
  logic [NUM_MASTERS-1:0]                  m_ack;
  logic [DATA_WIDTH-1:0]                   m_rdata;

  logic                                    mem_ce;
  logic                                    mem_we;
  logic [ADDR_WIDTH-1:0]                   mem_addr;
  logic [DATA_WIDTH/8-1:0]                 mem_sel;
  logic [DATA_WIDTH-1:0]                   mem_data_o;
  logic [DATA_WIDTH-1:0]                   mem_data_i;

  modport slave (
    input  m_req, m_we, m_addr, m_sel, m_wdata, mem_data_i,
    output m_ack, m_rdata, mem_ce, mem_we, mem_addr, mem_sel, mem_data_o
  );

  modport master (
    output m_req, m_we, m_addr, m_sel, m_wdata, mem_data_i,
    input  m_ack, m_rdata, mem_ce, mem_we, mem_addr, mem_sel, mem_data_o
  );

endinterface

// File: rtl/sopc_mem_arbiter_rr_arbiter.sv
// Combinational grant selection: fixed lowest-index priority or round-robin
// starting one past the last grant; output is one-hot or zero.
module rr_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int LGW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic           mode_i,
  input  logic [LGW-1:0] last_grant_i,
  output logic [N-1:0]   grant_o
);

  logic found;
  int   pos;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    if (mode_i == ARB_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && !found) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      // Walk offsets from last_grant+1, wrapping without a modulo operator.
      for (int o = 0; o < N; o++) begin
        pos = int'(last_grant_i) + 1 + o;
        if (pos >= N) pos = pos - N;
        if (pos >= N) pos = pos - N;
        for (int j = 0; j < N; j++) begin
          if (!found && req_i[j] && (j == pos)) begin
            grant_o[j] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares one synchronous memory among NUM_MASTERS requesters, one access in flight.
// Read ack MEM_LATENCY+1 cycles after the sampling edge, write ack after 2; requests held until ack.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MASTERS = 2,
  parameter int MEM_LATENCY = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  sopc_mem_arbiter_if.slave bus
);

  localparam int AW  = ADDR_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int SW  = DATA_WIDTH / 8;
  localparam int N   = NUM_MASTERS;
  localparam int LGW = idx_width(NUM_MASTERS);
  localparam int CW  = idx_width(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LGW-1:0]  win_q, win_d;
  logic [LGW-1:0]  last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_ce_q, mem_we_q;

  logic [N-1:0]    grant;
  logic [LGW-1:0]  g_idx;
  logic            g_we;
  logic [AW-1:0]   g_addr;
  logic [SW-1:0]   g_sel;
  logic [DW-1:0]   g_wdata;

  rr_arbiter #(.N(N), .LGW(LGW)) u_rr_arbiter (
    .req_i        (bus.m_req),
    .mode_i       ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  always_comb begin
    g_idx   = '0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_sel   = '0;
    g_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        g_idx   = LGW'(i);
        g_we    = bus.m_we[i];
        g_addr  = bus.m_addr[i*AW +: AW];
        g_sel   = bus.m_sel[i*SW +: SW];
        g_wdata = bus.m_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_req) begin
          state_d = ST_ACCESS;
          win_d   = g_idx;
          last_d  = g_idx;
          we_d    = g_we;
          addr_d  = g_addr;
          sel_d   = g_sel;
          wdata_d = g_wdata;
        end
      end
      ST_ACCESS: begin
        if (we_q || (MEM_LATENCY == 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!we_q) rdata_d = bus.mem_data_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      last_q   <= LGW'(N - 1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_ce_q <= CE_OFF;
      mem_we_q <= WE_READ;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      // Command enables are registered so they coincide exactly with ACCESS.
      mem_ce_q <= (state_d == ST_ACCESS) ? CE_ON : CE_OFF;
      mem_we_q <= (state_d == ST_ACCESS) ? we_d : WE_READ;
    end
  end

  always_comb begin
    bus.m_ack   = '0;
    bus.m_rdata = rdata_q;
    if (state_q == ST_DONE) begin
      for (int i = 0; i < N; i++) begin
        if (win_q == LGW'(i)) bus.m_ack[i] = 1'b1;
      end
      if (!we_q) bus.m_rdata = bus.mem_data_i;
    end
  end

  assign bus.mem_ce     = mem_ce_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_sel    = sel_q;
  assign bus.mem_data_o = wdata_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Two arbiter instances: k=0 fixed priority with 1-cycle memory, k=1 round-robin
// with 3-cycle memory, each with its own memory model and scoreboard.
module tb_sopc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  sopc_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2)) ifa ();
  sopc_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2)) ifb ();

  sopc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2), .MEM_LATENCY(1), .ARB_MODE(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sopc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2), .MEM_LATENCY(3), .ARB_MODE(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [1:0]  req [2];
  logic [1:0]  wem [2];
  logic [63:0] addr_b [2];
  logic [7:0]  sel_b [2];
  logic [63:0] wd_b [2];
  logic        ce [2];
  logic        mwe [2];
  logic [31:0] maddr [2];
  logic [3:0]  msel [2];
  logic [31:0] mdo [2];
  logic [1:0]  ack [2];
  logic [31:0] rdata [2];
  logic [31:0] bmem [2][256];
  logic [31:0] pipe [2][3];
  logic [15:0] cyc;

  assign ifa.m_req = req[0];    assign ifb.m_req = req[1];
  assign ifa.m_we = wem[0];     assign ifb.m_we = wem[1];
  assign ifa.m_addr = addr_b[0]; assign ifb.m_addr = addr_b[1];
  assign ifa.m_sel = sel_b[0];  assign ifb.m_sel = sel_b[1];
  assign ifa.m_wdata = wd_b[0]; assign ifb.m_wdata = wd_b[1];
  assign ifa.mem_data_i = pipe[0][0];
  assign ifb.mem_data_i = pipe[1][2];
  assign ce[0] = ifa.mem_ce;       assign ce[1] = ifb.mem_ce;
  assign mwe[0] = ifa.mem_we;      assign mwe[1] = ifb.mem_we;
  assign maddr[0] = ifa.mem_addr;  assign maddr[1] = ifb.mem_addr;
  assign msel[0] = ifa.mem_sel;    assign msel[1] = ifb.mem_sel;
  assign mdo[0] = ifa.mem_data_o;  assign mdo[1] = ifb.mem_data_o;
  assign ack[0] = ifa.m_ack;       assign ack[1] = ifb.m_ack;
  assign rdata[0] = ifa.m_rdata;   assign rdata[1] = ifb.m_rdata;

  function automatic logic [31:0] memval(input int k, input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1357_0000 ^ 32'(i * 32'h9E37) ^ 32'(k << 28);
  endfunction

  // Memory: read data presented exactly MEM_LATENCY cycles after the ce cycle,
  // otherwise a changing junk word so a mistimed capture is visible.
  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) bmem[k][i] <= memval(k, i);
      end else if (ce[k] && mwe[k]) begin
        for (int b = 0; b < 4; b++)
          if (msel[k][b]) bmem[k][maddr[k][9:2]][b*8 +: 8] <= mdo[k][b*8 +: 8];
      end
      pipe[k][0] <= (ce[k] && !mwe[k]) ? bmem[k][maddr[k][9:2]] : {16'hBAD0, cyc};
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [2][256];
  logic [31:0] rd_model [2];
  int          last_g [2];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic int lat_of(input int k);  return (k == 0) ? 1 : 3; endfunction
  function automatic bit is_rr(input int k);   return (k == 1); endfunction

  function automatic int pick(input int k, input logic [1:0] r);
    int s;
    if (!is_rr(k)) return r[0] ? 0 : 1;
    s = (last_g[k] + 1) % 2;
    return r[s] ? s : 1 - s;
  endfunction

  task automatic run_txn(input int k, input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit drop_early, input bit poke_other);
    int win, exp_lat, n;
    bit got;
    logic ew;
    logic [31:0] ea, ed, exp_rd;
    logic [3:0] es;
    @(negedge clk);
    req[k] = r; wem[k] = w; addr_b[k] = {a1, a0}; sel_b[k] = {s1, s0}; wd_b[k] = {d1, d0};
    win = pick(k, r);
    if (is_rr(k)) last_g[k] = win;
    ew = w[win]; ea = win ? a1 : a0; es = win ? s1 : s0; ed = win ? d1 : d0;
    exp_lat = ew ? 2 : lat_of(k) + 1;
    exp_rd = ew ? rd_model[k] : ref_mem[k][ea[9:2]];
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        n_checks++; if (ce[k] !== 1'b1) $display("FAIL ce_cycle1 k=%0d got %b want 1", k, ce[k]); else n_pass++;
        n_checks++; if (mwe[k] !== ew) $display("FAIL we_cycle1 k=%0d got %b want %b", k, mwe[k], ew); else n_pass++;
        n_checks++; if (maddr[k] !== ea) $display("FAIL addr_cycle1 k=%0d got %h want %h", k, maddr[k], ea); else n_pass++;
        n_checks++; if (msel[k] !== es) $display("FAIL sel_cycle1 k=%0d got %b want %b", k, msel[k], es); else n_pass++;
        n_checks++; if (mdo[k] !== ed) $display("FAIL wdata_cycle1 k=%0d got %h want %h", k, mdo[k], ed); else n_pass++;
        if (drop_early) req[k][win] = 1'b0;
        if (poke_other) req[k][1-win] = 1'b1;
      end else begin
        n_checks++; if (ce[k] !== 1'b0) $display("FAIL ce_extra k=%0d cycle %0d got %b want 0", k, n, ce[k]); else n_pass++;
      end
      if (ack[k] !== 2'b00) got = 1;
    end
    n_checks++; if (!got) $display("FAIL ack_timeout k=%0d no ack within %0d cycles", k, n); else n_pass++;
    n_checks++; if (ack[k] !== 2'(1 << win)) $display("FAIL ack_vec k=%0d got %b want %b", k, ack[k], 2'(1 << win)); else n_pass++;
    n_checks++; if (n != exp_lat) $display("FAIL ack_latency k=%0d got %0d want %0d", k, n, exp_lat); else n_pass++;
    n_checks++; if (rdata[k] !== exp_rd) $display("FAIL rdata_ack k=%0d got %h want %h", k, rdata[k], exp_rd); else n_pass++;
    req[k] = 2'b00;
    rd_model[k] = exp_rd;
    if (ew) for (int b = 0; b < 4; b++) if (es[b]) ref_mem[k][ea[9:2]][b*8 +: 8] = ed[b*8 +: 8];
    @(negedge clk);
    n_checks++; if (ack[k] !== 2'b00) $display("FAIL ack_pulse k=%0d got %b want 00", k, ack[k]); else n_pass++;
    n_checks++; if (rdata[k] !== exp_rd) $display("FAIL rdata_hold k=%0d got %h want %h", k, rdata[k], exp_rd); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (ce[k] !== 1'b0) $display("FAIL idle_ce k=%0d got %b want 0", k, ce[k]); else n_pass++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ack[k] !== 2'b00) $display("FAIL %s_ack k=%0d got %b want 00", tag, k, ack[k]); else n_pass++;
      n_checks++; if ({ce[k], mwe[k]} !== 2'b00) $display("FAIL %s_ce_we k=%0d got %b want 00", tag, k, {ce[k], mwe[k]}); else n_pass++;
      n_checks++; if ({maddr[k], msel[k], mdo[k]} !== 68'd0) $display("FAIL %s_cmd k=%0d got %h/%h/%h want 0", tag, k, maddr[k], msel[k], mdo[k]); else n_pass++;
      n_checks++; if (rdata[k] !== 32'd0) $display("FAIL %s_rdata k=%0d got %h want 0", tag, k, rdata[k]); else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_lat1();
    run_txn(0, 2'b01, 2'b00, 32'h10, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_read_lat3();
    run_txn(1, 2'b10, 2'b00, 32'h0, 32'h20, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    run_txn(0, 2'b01, 2'b01, 32'h40, 32'h0, 4'b0011, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0);
    run_txn(0, 2'b01, 2'b00, 32'h40, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fixed_priority();
    int acks, cycles;
    @(negedge clk);
    req[0] = 2'b11; wem[0] = 2'b00; addr_b[0] = {32'h44, 32'h10}; sel_b[0] = 8'hFF;
    acks = 0; cycles = 0;
    while (acks < 8 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (ack[0] !== 2'b00) begin
        acks++;
        n_checks++; if (ack[0] !== 2'b01) $display("FAIL fixed_winner got %b want 01", ack[0]); else n_pass++;
        n_checks++; if (rdata[0] !== ref_mem[0][4]) $display("FAIL fixed_rdata got %h want %h", rdata[0], ref_mem[0][4]); else n_pass++;
        if (acks == 8) req[0] = 2'b00;
      end
    end
    n_checks++; if (acks != 8) $display("FAIL fixed_ack_count got %0d want 8", acks); else n_pass++;
    rd_model[0] = ref_mem[0][4];
  endtask

  task automatic test_round_robin();
    int acks, cycles, e;
    @(negedge clk);
    req[1] = 2'b11; wem[1] = 2'b00; addr_b[1] = {32'h0C, 32'h08}; sel_b[1] = 8'hFF;
    acks = 0; cycles = 0;
    while (acks < 6 && cycles < 120) begin
      @(negedge clk);
      cycles++;
      if (ack[1] !== 2'b00) begin
        e = pick(1, 2'b11);
        last_g[1] = e;
        acks++;
        n_checks++; if (ack[1] !== 2'(1 << e)) $display("FAIL rr_winner #%0d got %b want %b", acks, ack[1], 2'(1 << e)); else n_pass++;
        n_checks++; if (rdata[1] !== ref_mem[1][2 + e]) $display("FAIL rr_rdata got %h want %h", rdata[1], ref_mem[1][2 + e]); else n_pass++;
        rd_model[1] = ref_mem[1][2 + e];
        if (acks == 6) req[1] = 2'b00;
      end
    end
    n_checks++; if (acks != 6) $display("FAIL rr_ack_count got %0d want 6", acks); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] r, w;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 12; t++) begin
        r = 2'($urandom_range(1, 3));
        w = 2'($urandom_range(0, 3));
        run_txn(k, r, w, 32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
                4'($urandom), 4'($urandom), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req[1] = 2'b01; wem[1] = 2'b00; addr_b[1] = {32'h0, 32'h10}; sel_b[1] = 8'hFF;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    req[1] = 2'b00;
    last_g[1] = 1;
    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++; if ({ack[0], ack[1]} !== 4'b0) $display("FAIL rst_wait_stray_ack got %b want 0000", {ack[0], ack[1]}); else n_pass++;
    end
    run_txn(1, 2'b11, 2'b00, 32'h10, 32'h14, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; wem[k] = '0; addr_b[k] = '0; sel_b[k] = '0; wd_b[k] = '0;
      rd_model[k] = '0; last_g[k] = 1;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = memval(k, i);
    end
    cyc = '0;
    test_reset();
    test_read_lat1();
    test_read_lat3();
    test_write();
    test_fixed_priority();
    test_round_robin();
    test_random();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
